// File: rtl/gray_share_pkg.sv
// Shared types, default widths and round-robin helper for the gray_share_arbiter slice.
// Contents: state_t (IDLE/CONV/RESULT), default NREQ/W/IDW, next_rr() pointer advance.
package gray_share_pkg;

  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned W_DEF    = 8;
  localparam int unsigned IDW_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    RESULT = 2'd2
  } state_t;

  // Pointer one past the winner, wrapping NREQ-1 -> 0.
  function automatic int unsigned next_rr(input int unsigned ptr, input int unsigned nreq);
    return ((ptr + 1) >= nreq) ? 0 : (ptr + 1);
  endfunction

endpackage

// File: rtl/gray_share_conv.sv
// Combinational W-bit Gray converter shared by all requesters.
// Ports: din (captured data), dout (converted code); mode (1 = Gray-to-binary)
// exists only when GRAY_SHARE_DECODE_EN is defined, otherwise always binary-to-Gray.
module gray_share_conv
  import gray_share_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
`ifdef GRAY_SHARE_DECODE_EN
  input  logic         mode,
`endif
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] enc;

  // Each Gray bit is the XOR of a data bit and its upper neighbour; MSB passes through.
  assign enc = din ^ (din >> 1);

`ifdef GRAY_SHARE_DECODE_EN
  logic [W-1:0] dec;

  // Unrolled MSB-first chain: binary bit k is the XOR of Gray bits k..W-1.
  always_comb begin
    dec = '0;
    for (int k = 0; k < W; k++) begin
      dec[k] = ^(din >> k);
    end
  end

  assign dout = mode ? dec : enc;
`else
  assign dout = enc;
`endif

endmodule

// File: rtl/gray_share_arbiter.sv
// Round-robin arbiter sharing one Gray converter among NREQ requesters.
// Ports: clk, rst (sync, active-high); req_valid/req_data/req_ready per requester
// (req_ready is combinational, one-hot or zero); out_valid/out_gcode/out_id/out_ready
// result port. Optional macro GRAY_SHARE_DECODE_EN adds req_mode (1 = Gray-to-binary).
module gray_share_arbiter
  import gray_share_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned W    = W_DEF,
  parameter int unsigned IDW  = IDW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
`ifdef GRAY_SHARE_DECODE_EN
  input  logic [NREQ-1:0]   req_mode,
`endif
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_gcode,
  output logic [IDW-1:0]    out_id,
  input  logic              out_ready
);

  localparam int unsigned SW = IDW + 1;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [W-1:0]   data_q, data_d;
  logic           vld_d;
  logic [W-1:0]   gcode_d;
  logic [IDW-1:0] oid_d;
  logic [W-1:0]   conv_out;

  logic [NREQ-1:0] rot;
  logic            found;
  logic [IDW-1:0]  winner;
  logic [SW-1:0]   sum;
  logic [W-1:0]    win_data;
  logic            grant;

`ifdef GRAY_SHARE_DECODE_EN
  logic mode_q, mode_d;
`endif

  // Rotate requests so the rr pointer lands on bit 0; lowest set bit is then the winner.
  assign rot = NREQ'({req_valid, req_valid} >> rr_q);

  always_comb begin
    found  = 1'b0;
    winner = rr_q;
    sum    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        sum   = SW'(rr_q) + SW'(i);
        if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
        winner = IDW'(sum);
      end
    end
  end

  assign win_data = W'(req_data >> (32'(winner) * W));

  // A grant is only offered when the converter slot is free in this cycle.
  assign grant = !rst && found &&
                 ((state_q == IDLE) || ((state_q == RESULT) && out_ready));

  assign req_ready = grant ? (NREQ'(1) << winner) : '0;

  gray_share_conv #(.W(W)) u_conv (
`ifdef GRAY_SHARE_DECODE_EN
    .mode (mode_q),
`endif
    .din  (data_q),
    .dout (conv_out)
  );

  // Next-state and next-register values.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    data_d  = data_q;
    vld_d   = out_valid;
    gcode_d = out_gcode;
    oid_d   = out_id;
`ifdef GRAY_SHARE_DECODE_EN
    mode_d  = mode_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant) begin
          data_d  = win_data;
          id_d    = winner;
          rr_d    = IDW'(next_rr(32'(winner), NREQ));
`ifdef GRAY_SHARE_DECODE_EN
          mode_d  = |(req_mode & req_ready);
`endif
          state_d = CONV;
        end
      end
      CONV: begin
        gcode_d = conv_out;
        oid_d   = id_q;
        vld_d   = 1'b1;
        state_d = RESULT;
      end
      RESULT: begin
        if (out_ready) begin
          vld_d = 1'b0;
          if (grant) begin
            data_d  = win_data;
            id_d    = winner;
            rr_d    = IDW'(next_rr(32'(winner), NREQ));
`ifdef GRAY_SHARE_DECODE_EN
            mode_d  = |(req_mode & req_ready);
`endif
            state_d = CONV;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      id_q      <= '0;
      data_q    <= '0;
      out_valid <= 1'b0;
      out_gcode <= '0;
      out_id    <= '0;
`ifdef GRAY_SHARE_DECODE_EN
      mode_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      id_q      <= id_d;
      data_q    <= data_d;
      out_valid <= vld_d;
      out_gcode <= gcode_d;
      out_id    <= oid_d;
`ifdef GRAY_SHARE_DECODE_EN
      mode_q    <= mode_d;
`endif
    end
  end

endmodule

// File: doc/gray_share_arbiter.md
Name: gray_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 8-bit binary-to-Gray conversion datapath between NREQ requesters.
- Accepts one request per grant, captures its data and converts it. Presents the Gray result with the requester ID on a single valid/ready output port.
- Sits between the requesting engines and the downstream Gray-code consumer.

Parameters:
- NREQ, 4, number of requesters (2..16)
- W, 8, data/code width in bits
- IDW, 2, width of the requester ID; must be at least clog2(NREQ)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  NREQ  per-requester request valid
- req_data  input  NREQ*W  packed data; requester i occupies bits [i*W +: W]
- req_ready  output  NREQ  per-requester grant/accept; at most one bit high (one-hot or zero)
- out_valid  output  1  converted result available
- out_gcode  output  W  Gray code of the granted data
- out_id  output  IDW  index of the requester that produced out_gcode
- out_ready  input  1  downstream accepts the result

Behaviour:
- Reset:
  - Synchronous and active-high; one clock clk.
  - On rst: state=IDLE, rr_ptr=0, out_valid=0, out_gcode=0, out_id=0, captured data=0.
  - req_ready is 0 while rst is high.
  - Reset mid-operation discards any captured or pending result with no output.
- States: IDLE, CONV, RESULT.
- IDLE:
  - If any req_valid bit is set, pick the winner: first set bit scanning rr_ptr, rr_ptr+1, ... (mod NREQ).
  - Drive req_ready[winner]=1 combinationally in the same cycle; the handshake completes in that cycle.
  - Capture req_data[winner] and the winner index.
  - Update rr_ptr=(winner+1) mod NREQ; go to CONV.
  - With no request, stay in IDLE with req_ready=0.
- CONV:
  - Register out_gcode: MSB = data MSB; bit k = data[k] XOR data[k+1] for k=W-2..0.
  - Register out_id = captured index; set out_valid=1; go to RESULT.
  - req_ready=0.
- RESULT:
  - Hold out_valid, out_gcode and out_id stable until out_ready=1.
  - On out_ready=1 with any req_valid set, grant the next winner in the same cycle (same RR rule) and go to CONV. out_valid drops next cycle.
  - On out_ready=1 with no request, go to IDLE with out_valid=0 next cycle.
- Timing:
  - Latency: grant cycle to out_valid = 2 cycles.
  - Sustained throughput with out_ready tied high: one result per 2 cycles.
- Requester rules:
  - A requester must hold req_valid and req_data stable until it sees req_ready.
  - The arbiter never grants a requester whose req_valid is 0.
- Boundaries:
  - rr_ptr wraps from NREQ-1 to 0.
  - Single active requester is granted every opportunity.
  - All requesters active are served in strict rotation.
  - Backpressure (out_ready=0) stalls indefinitely with no grants and no loss.
  - out_ready high while out_valid=0 is ignored.
- Zero data yields gcode 0. Data is never masked, so a zero result is indistinguishable from real data; qualify with out_valid.

Optional Feature:
- Macro: GRAY_SHARE_DECODE_EN.
- With the macro defined:
  - Adds port req_mode, input, NREQ bits.
  - Mode 0 = binary-to-Gray.
  - Mode 1 = Gray-to-binary: out MSB = in MSB; bit k = out[k+1] XOR in[k], computed MSB-first within CONV.
  - Mode is captured with the data at grant.
- Without the macro: no req_mode port; the block always encodes binary-to-Gray.

Decomposition:
- Package gray_share_pkg:
  - state enum {IDLE, CONV, RESULT}
  - default width constants
  - function next_rr(ptr, NREQ)
- One natural sub-module, gray_share_conv: purely combinational W-bit converter, with a mode input present only under GRAY_SHARE_DECODE_EN.
- Arbitration and FSM stay in the top module.

Test Plan:
- Reset then single request: req_valid=0001, req_data[0]=8'hB5 -> req_ready=0001 for one cycle; 2 cycles later out_valid=1, out_gcode=8'hEF, out_id=0.
- All four requesters valid continuously, out_ready=1 -> grant order 0,1,2,3,0; out_id sequence matches; one result every 2 cycles.
- Backpressure: result pending, out_ready=0 for 10 cycles with requests active -> out_valid stays 1, outputs stable, req_ready=0; release -> next grant in the release cycle.
- Boundary data: 8'h00 -> 8'h00; 8'hFF -> 8'h80; 8'h80 -> 8'hC0.
- Reset mid-operation: assert rst while in CONV -> next cycle out_valid=0, rr_ptr=0, state IDLE; a following request from requester 2 yields out_id=2.
- GRAY_SHARE_DECODE_EN, req_mode[1]=1, data 8'hEF -> out_gcode=8'hB5, out_id=1.
